// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 latches conditioned operands and group G/P; stage 2 resolves carries and flags.
module cla_adder_pipe #(
  parameter int WIDTH = 24,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             blk_gen,
  output logic             blk_prop
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > 8) begin : g_bad_cfg
      $error("cla_adder_pipe: WIDTH must be a multiple of GROUP and GROUP must be 2..8");
    end
  endgenerate

  logic             s1_adv, s2_adv;
  logic             vld_p1_q, vld_p2_q;

  // Stage 0: operand conditioning and per-group lookahead terms
  logic [WIDTH-1:0] b_eff_p0, g_p0, p_p0;
  logic             cin_eff_p0;
  logic [NG-1:0]    gg_p0, gp_p0;
  logic             gacc_p0, pacc_p0;

  always_comb begin
    b_eff_p0   = sub ? ~b : b;
    cin_eff_p0 = sub | c_in;
    g_p0       = a & b_eff_p0;
    p_p0       = a | b_eff_p0;
    gg_p0      = '0;
    gp_p0      = '0;
    gacc_p0    = 1'b0;
    pacc_p0    = 1'b1;
    for (int j = 0; j < NG; j++) begin
      gacc_p0 = 1'b0;
      pacc_p0 = 1'b1;
      for (int k = 0; k < GROUP; k++) begin
        gacc_p0 = g_p0[j*GROUP+k] | (p_p0[j*GROUP+k] & gacc_p0);
        pacc_p0 = pacc_p0 & p_p0[j*GROUP+k];
      end
      gg_p0[j] = gacc_p0;
      gp_p0[j] = pacc_p0;
    end
  end

  // Stage 1: registered operands and group terms
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic             cin_p1_q;
  logic [NG-1:0]    gg_p1_q, gp_p1_q;

  assign s2_adv   = !vld_p2_q | out_ready;
  assign s1_adv   = !vld_p1_q | s2_adv;
  assign in_ready = s1_adv;

  logic [WIDTH-1:0] g_p1, p_p1, c_p1;
  logic             cg_p1, cc_p1, bg_p1;
  logic [WIDTH-1:0] sum_p2_d;
  logic             c_out_p2_d, ovf_p2_d, zero_p2_d, blk_gen_p2_d, blk_prop_p2_d;

  always_comb begin
    g_p1  = a_p1_q & b_p1_q;
    p_p1  = a_p1_q | b_p1_q;
    c_p1  = '0;
    cg_p1 = cin_p1_q;
    cc_p1 = 1'b0;
    bg_p1 = 1'b0;
    for (int j = 0; j < NG; j++) begin
      // Ripple inside the group seeded by the group carry; group carry hops over via G/P.
      cc_p1 = cg_p1;
      for (int k = 0; k < GROUP; k++) begin
        c_p1[j*GROUP+k] = cc_p1;
        cc_p1 = g_p1[j*GROUP+k] | (p_p1[j*GROUP+k] & cc_p1);
      end
      cg_p1 = gg_p1_q[j] | (gp_p1_q[j] & cg_p1);
      bg_p1 = gg_p1_q[j] | (gp_p1_q[j] & bg_p1);
    end
    sum_p2_d      = a_p1_q ^ b_p1_q ^ c_p1;
    c_out_p2_d    = cg_p1;
    ovf_p2_d      = cg_p1 ^ c_p1[WIDTH-1];
    zero_p2_d     = (sum_p2_d == '0);
    blk_gen_p2_d  = bg_p1;
    blk_prop_p2_d = &gp_p1_q;
  end

  // Stage 2: registered results driving the outputs
  logic [WIDTH-1:0] sum_p2_q;
  logic             c_out_p2_q, ovf_p2_q, zero_p2_q, blk_gen_p2_q, blk_prop_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      a_p1_q        <= '0;
      b_p1_q        <= '0;
      cin_p1_q      <= 1'b0;
      gg_p1_q       <= '0;
      gp_p1_q       <= '0;
      sum_p2_q      <= '0;
      c_out_p2_q    <= 1'b0;
      ovf_p2_q      <= 1'b0;
      zero_p2_q     <= 1'b0;
      blk_gen_p2_q  <= 1'b0;
      blk_prop_p2_q <= 1'b0;
    end else begin
      if (s1_adv) vld_p1_q <= in_valid;
      if (in_valid && s1_adv) begin
        a_p1_q   <= a;
        b_p1_q   <= b_eff_p0;
        cin_p1_q <= cin_eff_p0;
        gg_p1_q  <= gg_p0;
        gp_p1_q  <= gp_p0;
      end
      if (s2_adv) vld_p2_q <= vld_p1_q;
      if (vld_p1_q && s2_adv) begin
        sum_p2_q      <= sum_p2_d;
        c_out_p2_q    <= c_out_p2_d;
        ovf_p2_q      <= ovf_p2_d;
        zero_p2_q     <= zero_p2_d;
        blk_gen_p2_q  <= blk_gen_p2_d;
        blk_prop_p2_q <= blk_prop_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign c_out     = c_out_p2_q;
  assign ovf       = ovf_p2_q;
  assign zero      = zero_p2_q;
  assign blk_gen   = blk_gen_p2_q;
  assign blk_prop  = blk_prop_p2_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe (WIDTH=8, GROUP=4): directed cases, backpressure, reset, random traffic
// checked against an arithmetic reference model through an in-order expectation queue.
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
    logic       zero;
    logic       gen;
    logic       prop;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       sub, c_in;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       c_out, ovf, zero, blk_gen, blk_prop;

  cla_adder_pipe #(.WIDTH(8), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero),
    .blk_gen(blk_gen), .blk_prop(blk_prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  res_t q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   nin = 0;
  int   nout = 0;
  logic s_ov, s_ir, prev_stall;
  res_t s_res, prev_res;

  function automatic res_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic isub, input logic icin);
    res_t       r;
    logic [7:0] be;
    logic [8:0] full;
    be      = isub ? ~ib : ib;
    full    = {1'b0, ia} + {1'b0, be} + {8'd0, (isub ? 1'b1 : icin)};
    r.sum   = full[7:0];
    r.c_out = full[8];
    r.ovf   = (ia[7] == be[7]) && (full[7] != ia[7]);
    r.zero  = (full[7:0] == 8'd0);
    r.gen   = (({1'b0, ia} + {1'b0, be}) > 9'd255);
    r.prop  = ((ia | be) == 8'hFF);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, score handshakes, advance past posedge.
  task automatic cyc(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                     input logic isub, input logic icin, input logic ordy);
    res_t e;
    in_valid = iv; a = ia; b = ib; sub = isub; c_in = icin; out_ready = ordy;
    @(negedge clk);
    s_ov  = out_valid;
    s_ir  = in_ready;
    s_res = {sum, c_out, ovf, zero, blk_gen, blk_prop};
    if (prev_stall) begin
      check("hold_valid", 32'(s_ov), 32'd1);
      check("hold_data", 32'(s_res), 32'(prev_res));
    end
    if (s_ov && ordy) begin
      if (q.size() == 0) check("spurious_out", 32'(s_ov), 32'd0);
      else begin
        e = q.pop_front();
        check("result", 32'(s_res), 32'(e));
        nout++;
      end
    end
    if (iv && s_ir && rst_n) begin
      q.push_back(model(ia, ib, isub, icin));
      nin++;
    end
    prev_stall = s_ov && !ordy && rst_n;
    prev_res   = s_res;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Single beat with an unstalled sink; s_res holds the result afterwards.
  task automatic one(input logic [7:0] ia, input logic [7:0] ib, input logic isub, input logic icin);
    cyc(1'b1, ia, ib, isub, icin, 1'b1);
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    logic ordy;
    prev_stall = 1'b0;
    prev_res   = '0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({sum, c_out, ovf, zero, blk_gen, blk_prop}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency: accept at cycle 0, valid in cycle 2
    cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    check("in_ready_after_reset", 32'(s_ir), 32'd1);
    idle(1);
    check("lat_cycle1_ov", 32'(s_ov), 32'd0);
    idle(1);
    check("lat_cycle2_ov", 32'(s_ov), 32'd1);
    check("ff_01_sum", 32'(s_res.sum), 32'h00);
    check("ff_01_cout", 32'(s_res.c_out), 32'd1);
    check("ff_01_zero", 32'(s_res.zero), 32'd1);
    check("ff_01_ovf", 32'(s_res.ovf), 32'd0);

    one(8'h7F, 8'h01, 1'b0, 1'b0);
    check("7f_01_sum", 32'(s_res.sum), 32'h80);
    check("7f_01_ovf", 32'(s_res.ovf), 32'd1);
    check("7f_01_cout", 32'(s_res.c_out), 32'd0);
    one(8'hF0, 8'h0F, 1'b0, 1'b0);
    check("f0_0f_sum", 32'(s_res.sum), 32'hFF);
    check("f0_0f_prop", 32'(s_res.prop), 32'd1);
    check("f0_0f_gen", 32'(s_res.gen), 32'd0);
    one(8'hF0, 8'h0F, 1'b0, 1'b1);
    check("f0_0f_ci_sum", 32'(s_res.sum), 32'h00);
    check("f0_0f_ci_cout", 32'(s_res.c_out), 32'd1);

    one(8'h05, 8'h07, 1'b1, 1'b0);
    check("05m07_sum", 32'(s_res.sum), 32'hFE);
    check("05m07_cout", 32'(s_res.c_out), 32'd0);
    check("05m07_ovf", 32'(s_res.ovf), 32'd0);
    one(8'h80, 8'h01, 1'b1, 1'b1);
    check("80m01_sum", 32'(s_res.sum), 32'h7F);
    check("80m01_cout", 32'(s_res.c_out), 32'd1);
    check("80m01_ovf", 32'(s_res.ovf), 32'd1);
    one(8'h3C, 8'h3C, 1'b1, 1'b0);
    check("3cm3c_sum", 32'(s_res.sum), 32'h00);
    check("3cm3c_zero", 32'(s_res.zero), 32'd1);
    check("3cm3c_cout", 32'(s_res.c_out), 32'd1);

    // Backpressure: four beats, sink stalled during cycles 2..4
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || q.size() != 0); c++) begin
      ordy = !(c >= 2 && c <= 4);
      cyc(idx < 4, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, ordy);
      if (idx < 4 && s_ir) idx++;
      if (c == 2) check("bp_in_ready_full", 32'(s_ir), 32'd0);
      if (c == 3) check("bp_held_sum", 32'(s_res.sum), 32'h02);
    end
    check("bp_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset with both stages occupied
    cyc(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    check("pre_reset_ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ov", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    q.delete();
    nin = nout;
    prev_stall = 1'b0;
    idle(2);
    rst_n = 1'b1;
    one(8'h10, 8'h20, 1'b0, 1'b0);
    check("post_rst_ov", 32'(s_ov), 32'd1);
    check("post_rst_sum", 32'(s_res.sum), 32'h30);

    // Random traffic with random sink stalls
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    check("rand_drained", 32'(q.size()), 32'd0);
    check("beats_in_eq_out", 32'(nout), 32'(nin));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
